// File: rtl/fft_uart_pkg.sv
// Shared FSM encoding and sizing helpers for the FFT result UART serializer.
package fft_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bytes per word; the top byte of a word is zero-padded when it does not fill a whole byte.
    function automatic int calc_bpw(input int word_size, input int data_length);
        return (word_size + data_length - 1) / data_length;
    endfunction

    function automatic int calc_total_bytes(input int header_en, input int n_words,
                                            input int bpw, input int checksum_en);
        return header_en + n_words * bpw + checksum_en;
    endfunction

endpackage

// File: rtl/frame_byte_selector.sv
// Picks the byte at a given frame position: header, zero-padded payload byte, or checksum.
module frame_byte_selector
    import fft_uart_pkg::*;
#(
    parameter int                     N_WORDS     = 32,
    parameter int                     WORD_SIZE   = 16,
    parameter int                     DATA_LENGTH = 8,
    parameter int                     HEADER_EN   = 1,
    parameter logic [DATA_LENGTH-1:0] HEADER_BYTE = DATA_LENGTH'(8'hA5),
    parameter int                     CHECKSUM_EN = 1,
    parameter int                     IDX_W       = 7
) (
    input  logic [N_WORDS*WORD_SIZE-1:0] frame,
    input  logic [IDX_W-1:0]             idx,
    input  logic [DATA_LENGTH-1:0]       checksum,
    output logic [DATA_LENGTH-1:0]       byte_out,
    output logic                         is_payload
);

    localparam int BPW     = calc_bpw(WORD_SIZE, DATA_LENGTH);
    localparam int SLOT    = BPW * DATA_LENGTH;
    localparam int PAYLOAD = N_WORDS * BPW;

    logic [N_WORDS*SLOT-1:0] padded;
    logic [IDX_W-1:0]        pidx;

    // Each word gets a whole number of byte slots; unused upper bits stay zero.
    always_comb begin
        padded = '0;
        for (int k = 0; k < N_WORDS; k++) begin
            padded[k*SLOT +: WORD_SIZE] = frame[k*WORD_SIZE +: WORD_SIZE];
        end
    end

    assign pidx = idx - IDX_W'(HEADER_EN);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        byte_out   = '0;
        is_payload = 1'b0;
        if (HEADER_EN != 0 && idx == '0) begin
            byte_out = HEADER_BYTE;
        end else if (idx < IDX_W'(HEADER_EN + PAYLOAD)) begin
            is_payload = 1'b1;
            byte_out   = padded[pidx*DATA_LENGTH +: DATA_LENGTH];
        end else if (CHECKSUM_EN != 0) begin
            byte_out = checksum;
        end
    end

endmodule

// File: rtl/fft_result_serializer.sv
// Snapshots an FFT result frame and feeds it byte by byte to a UART transmitter,
// with optional header and payload checksum.
module fft_result_serializer
    import fft_uart_pkg::*;
#(
    parameter int                     N_WORDS     = 32,
    parameter int                     WORD_SIZE   = 16,
    parameter int                     DATA_LENGTH = 8,
    parameter int                     HEADER_EN   = 1,
    parameter logic [DATA_LENGTH-1:0] HEADER_BYTE = DATA_LENGTH'(8'hA5),
    parameter int                     CHECKSUM_EN = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_frame_valid,
    input  logic [N_WORDS*WORD_SIZE-1:0] i_frame_data,
    input  logic                         i_abort,
    input  logic                         i_TX_done,
    output logic                         o_TX_start,
    output logic [DATA_LENGTH-1:0]       o_TX_byte,
    output logic                         o_busy,
    output logic                         o_frame_done,
    output logic                         o_overrun
);

    localparam int BPW   = calc_bpw(WORD_SIZE, DATA_LENGTH);
    localparam int TOTAL = calc_total_bytes(HEADER_EN, N_WORDS, BPW, CHECKSUM_EN);
    localparam int IDX_W = $clog2(TOTAL + 1);

    state_t                       state;
    logic [N_WORDS*WORD_SIZE-1:0] frame_q;
    logic [N_WORDS*WORD_SIZE-1:0] sel_frame;
    logic [IDX_W-1:0]             byte_idx;
    logic [IDX_W-1:0]             sel_idx;
    logic [DATA_LENGTH-1:0]       checksum_q;
    logic [DATA_LENGTH-1:0]       sel_byte;
    logic [DATA_LENGTH-1:0]       sum_next;
    logic                         sel_payload;
    logic                         is_last;

    // The byte register is loaded one step ahead: in IDLE the first byte comes
    // straight from the incoming frame, otherwise the next byte from the snapshot.
    assign sel_frame = (state == IDLE) ? i_frame_data : frame_q;
    assign sel_idx   = (state == IDLE) ? '0 : byte_idx + IDX_W'(1);
    assign sum_next  = ((state == IDLE) ? '0 : checksum_q) + (sel_payload ? sel_byte : '0);
    assign is_last   = (byte_idx == IDX_W'(TOTAL - 1));

    frame_byte_selector #(
        .N_WORDS     (N_WORDS),
        .WORD_SIZE   (WORD_SIZE),
        .DATA_LENGTH (DATA_LENGTH),
        .HEADER_EN   (HEADER_EN),
        .HEADER_BYTE (HEADER_BYTE),
        .CHECKSUM_EN (CHECKSUM_EN),
        .IDX_W       (IDX_W)
    ) u_selector (
        .frame      (sel_frame),
        .idx        (sel_idx),
        .checksum   (checksum_q),
        .byte_out   (sel_byte),
        .is_payload (sel_payload)
    );

    // NOTE: the snapshot has no reset; it is only ever read after a capture has reloaded it.
    always_ff @(posedge i_clk) begin
        if (state == IDLE && i_frame_valid) begin
            frame_q <= i_frame_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            byte_idx     <= '0;
            checksum_q   <= '0;
            o_TX_start   <= 1'b0;
            o_TX_byte    <= '0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_TX_start   <= 1'b0;
            o_frame_done <= 1'b0;
            o_overrun    <= i_frame_valid && (state != IDLE);

            if (state != IDLE && i_abort) begin
                state  <= IDLE;
                o_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_frame_valid) begin
                            state      <= START;
                            o_busy     <= 1'b1;
                            o_TX_start <= 1'b1;
                            byte_idx   <= '0;
                            o_TX_byte  <= sel_byte;
                            checksum_q <= sum_next;
                        end
                    end
                    START: state <= WAIT;
                    WAIT: begin
                        if (i_TX_done) begin
                            if (is_last) begin
                                state        <= DONE;
                                o_frame_done <= 1'b1;
                                o_busy       <= 1'b0;
                            end else begin
                                state      <= START;
                                o_TX_start <= 1'b1;
                                byte_idx   <= byte_idx + IDX_W'(1);
                                o_TX_byte  <= sel_byte;
                                checksum_q <= sum_next;
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fft_result_serializer.sv
// Randomized bench: two serializer configurations checked against a byte-list model of the frame format.
module tb_fft_result_serializer;

    localparam int N0  = 32;
    localparam int WS0 = 16;
    localparam int N1  = 4;
    localparam int WS1 = 12;

    typedef enum int {M_NORMAL, M_OVERRUN, M_ABORT, M_COINC} mode_t;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    logic              frame_valid0 = 1'b0;
    logic [N0*WS0-1:0] frame_data0  = '0;
    logic              abort0       = 1'b0;
    logic              tx_done0;
    logic              tx_start0, busy0, frame_done0, overrun0;
    logic [7:0]        tx_byte0;

    logic              frame_valid1 = 1'b0;
    logic [N1*WS1-1:0] frame_data1  = '0;
    logic              abort1       = 1'b0;
    logic              tx_done1;
    logic              tx_start1, busy1, frame_done1, overrun1;
    logic [7:0]        tx_byte1;

    fft_result_serializer dut0 (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_frame_valid(frame_valid0),
        .i_frame_data (frame_data0),
        .i_abort      (abort0),
        .i_TX_done    (tx_done0),
        .o_TX_start   (tx_start0),
        .o_TX_byte    (tx_byte0),
        .o_busy       (busy0),
        .o_frame_done (frame_done0),
        .o_overrun    (overrun0)
    );

    fft_result_serializer #(
        .N_WORDS    (N1),
        .WORD_SIZE  (WS1),
        .HEADER_EN  (0),
        .CHECKSUM_EN(0)
    ) dut1 (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_frame_valid(frame_valid1),
        .i_frame_data (frame_data1),
        .i_abort      (abort1),
        .i_TX_done    (tx_done1),
        .o_TX_start   (tx_start1),
        .o_TX_byte    (tx_byte1),
        .o_busy       (busy1),
        .o_frame_done (frame_done1),
        .o_overrun    (overrun1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Frame format model: plain list of bytes built from the word values.
    int exp_q[$];
    int words_q[$];

    function automatic void model(input int words[$], input int ws, input int he, input int ce);
        int bpw, sum, v, b;
        exp_q.delete();
        sum = 0;
        bpw = (ws + 7) / 8;
        if (he != 0) exp_q.push_back('hA5);
        foreach (words[w]) begin
            v = words[w] & ((1 << ws) - 1);
            for (int j = 0; j < bpw; j++) begin
                b = (v >> (8 * j)) & 'hFF;
                sum += b;
                exp_q.push_back(b);
            end
        end
        if (ce != 0) exp_q.push_back(sum & 'hFF);
    endfunction

    // Transmitter models: record each started byte, answer with a done pulse.
    int rx0[$];
    int rx1[$];

    initial begin
        logic [7:0] b;
        tx_done0 = 1'b0;
        @(negedge i_clk);
        forever begin
            if (tx_start0 === 1'b1) begin
                b = tx_byte0;
                rx0.push_back(int'(b));
                @(negedge i_clk);
                check("start_pulse", tx_start0, 0);
                repeat (3) @(negedge i_clk);
                if (busy0) check("hold", tx_byte0, b);
                tx_done0 = 1'b1;
                @(negedge i_clk);
                tx_done0 = 1'b0;
            end else begin
                @(negedge i_clk);
            end
        end
    end

    initial begin
        tx_done1 = 1'b0;
        @(negedge i_clk);
        forever begin
            if (tx_start1 === 1'b1) begin
                rx1.push_back(int'(tx_byte1));
                @(negedge i_clk);
                tx_done1 = 1'b1;
                @(negedge i_clk);
                tx_done1 = 1'b0;
            end else begin
                @(negedge i_clk);
            end
        end
    end

    int fd0 = 0, ov0 = 0, fd1 = 0, ov1 = 0;
    always @(negedge i_clk) begin
        if (frame_done0) fd0++;
        if (overrun0)    ov0++;
        if (frame_done1) fd1++;
        if (overrun1)    ov1++;
    end

    task automatic rand_words(input int n, input int ws);
        words_q.delete();
        for (int k = 0; k < n; k++) words_q.push_back(int'($urandom_range(0, (1 << ws) - 1)));
    endtask

    task automatic run_frame0(input mode_t mode, input string name);
        int  rx_base, fd_base, ov_base, starts, n_exp;
        bit  finished;
        rx_base  = rx0.size();
        fd_base  = fd0;
        ov_base  = ov0;
        starts   = 0;
        finished = 1'b0;
        for (int k = 0; k < N0; k++) frame_data0[k*WS0 +: WS0] = 16'(words_q[k]);
        model(words_q, WS0, 1, 1);

        @(negedge i_clk);
        frame_valid0 = 1'b1;
        @(negedge i_clk);
        frame_valid0 = 1'b0;
        check({name, "_busy"}, busy0, 1);

        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            if (frame_valid0) frame_valid0 = 1'b0;
            if (tx_start0) begin
                starts++;
                if (mode == M_OVERRUN && starts == 11) begin
                    frame_valid0 = 1'b1;
                    frame_data0  = {N0{16'h5A5A}};
                end
                if (mode == M_ABORT && starts == 4) begin
                    @(negedge i_clk);
                    abort0 = 1'b1;
                    @(negedge i_clk);
                    abort0 = 1'b0;
                    check({name, "_abort_busy"}, busy0, 0);
                    check({name, "_abort_done"}, frame_done0, 0);
                    finished = 1'b1;
                end
                if (mode == M_COINC && starts == exp_q.size()) begin
                    repeat (4) @(negedge i_clk);
                    frame_valid0 = 1'b1;
                    @(negedge i_clk);
                    frame_valid0 = 1'b0;
                end
            end
            if (fd0 > fd_base) finished = 1'b1;
            if (!finished) @(negedge i_clk);
        end
        check({name, "_finished"}, finished, 1);

        repeat (12) begin
            @(negedge i_clk);
            if (tx_start0) starts++;
        end

        n_exp = (mode == M_ABORT) ? 4 : exp_q.size();
        check({name, "_nbytes"}, rx0.size() - rx_base, n_exp);
        check({name, "_starts"}, starts, n_exp);
        for (int i = 0; i < n_exp; i++) begin
            if (rx_base + i < rx0.size())
                check($sformatf("%s_byte%0d", name, i), rx0[rx_base + i], exp_q[i]);
        end
        check({name, "_frame_done"}, fd0 - fd_base, (mode == M_ABORT) ? 0 : 1);
        check({name, "_overrun"}, ov0 - ov_base, (mode == M_OVERRUN || mode == M_COINC) ? 1 : 0);
        check({name, "_idle"}, busy0, 0);
    endtask

    task automatic run_frame1(input string name);
        int rx_base, fd_base, ov_base;
        bit finished;
        rx_base  = rx1.size();
        fd_base  = fd1;
        ov_base  = ov1;
        finished = 1'b0;
        for (int k = 0; k < N1; k++) frame_data1[k*WS1 +: WS1] = 12'(words_q[k]);
        model(words_q, WS1, 0, 0);

        @(negedge i_clk);
        frame_valid1 = 1'b1;
        @(negedge i_clk);
        frame_valid1 = 1'b0;
        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            @(negedge i_clk);
            if (fd1 > fd_base) finished = 1'b1;
        end
        check({name, "_finished"}, finished, 1);
        repeat (5) @(negedge i_clk);

        check({name, "_nbytes"}, rx1.size() - rx_base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (rx_base + i < rx1.size())
                check($sformatf("%s_byte%0d", name, i), rx1[rx_base + i], exp_q[i]);
        end
        check({name, "_frame_done"}, fd1 - fd_base, 1);
        check({name, "_overrun"}, ov1 - ov_base, 0);
    endtask

    task automatic reset_test();
        int starts, cyc;
        rand_words(N0, WS0);
        for (int k = 0; k < N0; k++) frame_data0[k*WS0 +: WS0] = 16'(words_q[k]);
        @(negedge i_clk);
        frame_valid0 = 1'b1;
        @(negedge i_clk);
        frame_valid0 = 1'b0;
        starts = 0;
        cyc    = 0;
        while (starts < 3 && cyc < 2000) begin
            if (tx_start0) starts++;
            if (starts < 3) begin
                @(negedge i_clk);
                cyc++;
            end
        end
        check("rst_reach", starts, 3);

        @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        check("rst_start", tx_start0, 0);
        check("rst_byte", tx_byte0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", frame_done0, 0);
        check("rst_overrun", overrun0, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        starts = 0;
        repeat (40) begin
            @(negedge i_clk);
            if (tx_start0) starts++;
        end
        check("rst_no_restart", starts, 0);
        check("rst_idle", busy0, 0);
    endtask

    initial begin
        #12;
        check("init_start", tx_start0, 0);
        check("init_byte", tx_byte0, 0);
        check("init_busy", busy0, 0);
        check("init_done", frame_done0, 0);
        check("init_overrun", overrun0, 0);
        check("init_busy1", busy1, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        words_q.delete();
        for (int k = 0; k < N0; k++) words_q.push_back('h0100 + k);
        run_frame0(M_NORMAL, "dflt");

        for (int r = 0; r < 2; r++) begin
            rand_words(N0, WS0);
            run_frame0(M_NORMAL, $sformatf("rnd%0d", r));
        end

        rand_words(N0, WS0);
        run_frame0(M_OVERRUN, "ovr");

        rand_words(N0, WS0);
        run_frame0(M_ABORT, "abort");
        repeat (10) @(negedge i_clk);
        rand_words(N0, WS0);
        run_frame0(M_NORMAL, "post_abort");

        rand_words(N0, WS0);
        run_frame0(M_COINC, "coinc");

        reset_test();
        rand_words(N0, WS0);
        run_frame0(M_NORMAL, "post_rst");

        words_q.delete();
        for (int k = 0; k < N1; k++) words_q.push_back('hABC);
        run_frame1("pad");
        for (int r = 0; r < 2; r++) begin
            rand_words(N1, WS1);
            run_frame1($sformatf("pad_rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_result_serializer.md
FFT_RESULT_SERIALIZER -- requirements
Module: fft_result_serializer

Interface
REQ-001 SHALL have parameter N_WORDS, default 32, number of result words per frame (1..256).
REQ-002 SHALL have parameter WORD_SIZE, default 16, bits per result word.
REQ-003 SHALL have parameter DATA_LENGTH, default 8, bits per transmitted byte.
REQ-004 SHALL have parameter HEADER_EN, default 1, prepend header byte when 1.
REQ-005 SHALL have parameter HEADER_BYTE, default 8'hA5, header value.
REQ-006 SHALL have parameter CHECKSUM_EN, default 1, append checksum byte when 1.
REQ-007 SHALL have port i_clk, input, 1, the single clock.
REQ-008 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port i_frame_valid, input, 1, one-cycle pulse when the FFT frame is complete.
REQ-010 SHALL have port i_frame_data, input, N_WORDS*WORD_SIZE, flattened words, word k at bits [k*WORD_SIZE +: WORD_SIZE].
REQ-011 SHALL have port i_abort, input, 1, synchronous abort of the current frame.
REQ-012 SHALL have port i_TX_done, input, 1, UART transmitter byte-complete pulse.
REQ-013 SHALL have port o_TX_start, output, 1, one-cycle byte-start pulse to the transmitter.
REQ-014 SHALL have port o_TX_byte, output, DATA_LENGTH, byte to transmit.
REQ-015 SHALL have port o_busy, output, 1, high while a frame is in progress; used to gate the receiver.
REQ-016 SHALL have port o_frame_done, output, 1, one-cycle pulse after the last byte's i_TX_done.
REQ-017 SHALL have port o_overrun, output, 1, one-cycle pulse when i_frame_valid arrives while busy.

Function
REQ-018 SHALL compute BPW = ceil(WORD_SIZE/DATA_LENGTH); the top byte of each word is zero-padded.
REQ-019 SHALL, on i_frame_valid in IDLE, snapshot i_frame_data in the same edge; o_busy goes high on that edge.
REQ-020 SHALL transmit the sequence [header], word0 byte0 (LS byte first) .. word0 byte BPW-1, word1 .., word N_WORDS-1, [checksum].
REQ-021 SHALL compute the checksum as the modulo-2^DATA_LENGTH sum of payload bytes only, excluding the header.
REQ-022 SHALL implement FSM states IDLE -> START -> WAIT -> (START | DONE) -> IDLE.
REQ-023 SHALL assert o_TX_start for exactly one cycle in START; the first START is the cycle after capture.
REQ-024 SHALL hold o_TX_byte stable from START until i_TX_done is seen in WAIT.
REQ-025 SHALL, on i_TX_done in WAIT, advance the byte index and go to START, or go to DONE if the byte was last.
REQ-026 SHALL, in DONE, pulse o_frame_done for one cycle, deassert o_busy, and return to IDLE.
REQ-027 SHALL ignore i_TX_done outside WAIT.
REQ-028 SHALL ignore i_frame_valid while not IDLE and pulse o_overrun; this includes a pulse coincident with the last i_TX_done or with DONE.
REQ-029 SHALL, on i_abort in any non-IDLE state, go to IDLE next cycle with o_busy=0 and no o_frame_done; i_abort has priority over i_TX_done.
REQ-030 SHALL accept i_frame_valid in the first IDLE cycle after DONE or abort.
REQ-031 SHALL size the byte index as $clog2(total_bytes+1), where total_bytes = HEADER_EN + N_WORDS*BPW + CHECKSUM_EN.

Reset
REQ-032 SHALL, on i_rst_n=0, go immediately to IDLE with o_TX_start=0, o_TX_byte=0, o_busy=0, o_frame_done=0, o_overrun=0, byte index=0 and checksum=0.
REQ-033 SHALL, on reset mid-frame, discard the frame; after release, no byte is started until a new i_frame_valid.

Structure
REQ-034 SHALL place the FSM state encoding and the BPW/total_bytes helper functions in shared package fft_uart_pkg.
REQ-035 SHALL use one sub-module, frame_byte_selector: combinational byte select from the snapshot and index, including padding.

Verification
REQ-036 SHALL test defaults with words k=16'h0100+k: i_TX_done 5 cycles after each start gives 66 bytes A5,00,01,01,01,..,1F,01,checksum=8'h00+sum; o_frame_done once.
REQ-037 SHALL test N_WORDS=4, WORD_SIZE=12, HEADER_EN=0, CHECKSUM_EN=0, words 12'hABC: 8 bytes BC,0A repeated, with 0A having zero-padded upper nibble.
REQ-038 SHALL test i_frame_valid at byte 10 of 66: o_overrun pulses once and the frame continues unaltered.
REQ-039 SHALL test i_abort while waiting for byte 3: o_busy=0 next cycle, no frame_done, and a new frame afterwards starts with the header.
REQ-040 SHALL test i_rst_n low mid-WAIT: all outputs 0 asynchronously, and no o_TX_start after release without i_frame_valid.
REQ-041 SHALL test i_frame_valid coincident with the last i_TX_done: o_overrun=1 and the frame is not restarted.
